// File: rtl/mux21_ctrl_pkg.sv
// Shared encodings for the round-robin 2:1 channel arbiter: FSM state codes
// and the select values driven onto the gate-level mux cells.
package mux21_ctrl_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] G0   = 2'b01;
  localparam logic [1:0] G1   = 2'b10;

  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;

endpackage : mux21_ctrl_pkg

// File: rtl/rr_pick2.sv
// Combinational next-grant picker for two requesters: round-robin on ties,
// hand-off without an idle bubble, and burst preemption under contention.
module rr_pick2
  import mux21_ctrl_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic [1:0] cur_state,
  input  logic       burst_done,
  output logic [1:0] next_state
);

  // NOTE: default assignment first so every path through the case drives
  // next_state; a missing branch would otherwise infer a latch.
  always_comb begin
    next_state = IDLE;
    case (cur_state)
      IDLE: begin
        if (req0 && req1)  next_state = last ? G0 : G1;
        else if (req0)     next_state = G0;
        else if (req1)     next_state = G1;
        else               next_state = IDLE;
      end
      G0: begin
        if (!req0)                  next_state = req1 ? G1 : IDLE;
        else if (req1 && burst_done) next_state = G1;
        else                        next_state = G0;
      end
      G1: begin
        if (!req1)                  next_state = req0 ? G0 : IDLE;
        else if (req0 && burst_done) next_state = G0;
        else                        next_state = G1;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule : rr_pick2

// File: rtl/rr_mux21_arbiter.sv
// Round-robin arbiter for one shared 2:1 datapath channel: owns the grant FSM,
// burst counter, registered mux select and the registered output sample.
module rr_mux21_arbiter
  import mux21_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy
);

  localparam int               CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             burst_done;

  assign burst_done = (cnt_q == CNT_MAX);

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last       (last_q),
    .cur_state  (state_q),
    .burst_done (burst_done),
    .next_state (state_d)
  );

  always_comb begin
    s_d    = s_q;
    last_d = last_q;
    cnt_d  = '0;
    if (state_d != state_q && state_d == G0) begin
      s_d    = SEL_D0;
      last_d = 1'b0;
    end else if (state_d != state_q && state_d == G1) begin
      s_d    = SEL_D1;
      last_d = 1'b1;
    end else if (state_d == state_q && state_d != IDLE) begin
      cnt_d = burst_done ? cnt_q : cnt_q + 1'b1;
    end
  end

  // In Gk the registered select already equals k, so the sample follows s_q.
  always_comb begin
    y_d       = y_q;
    y_valid_d = 1'b0;
    if ((state_q == G0 && req0) || (state_q == G1 && req1)) begin
      y_d       = (s_q == SEL_D1) ? d1 : d0;
      y_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      s_q       <= SEL_D0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      s_q       <= s_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign gnt0    = (state_q == G0);
  assign gnt1    = (state_q == G1);
  assign busy    = (state_q != IDLE);
  assign s       = s_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

  grant_onehot: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));

endmodule : rr_mux21_arbiter

// File: tb/tb_rr_mux21_arbiter.sv
// Directed bench for rr_mux21_arbiter: a MAX_BURST=4 instance for the main
// sequence and a MAX_BURST=1 instance for the every-cycle alternation case.
module tb_rr_mux21_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] d0, d1;

  logic       gnt0, gnt1, s, y_valid, busy;
  logic [7:0] y;
  logic       b_gnt0, b_gnt1, b_s, b_y_valid, b_busy;
  logic [7:0] b_y;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_mux21_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .s(s), .y(y), .y_valid(y_valid), .busy(busy)
  );

  rr_mux21_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .s(b_s), .y(b_y), .y_valid(b_y_valid), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {gnt0, gnt1, s, busy, y_valid, y}
  function automatic logic [31:0] pk(input logic g0, input logic g1, input logic sel,
                                     input logic bsy, input logic v, input logic [7:0] yy);
    return {19'd0, g0, g1, sel, bsy, v, yy};
  endfunction

  initial begin
    logic g0_exp, prev_g0;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    tick(); tick();
    check("reset_state", pk(gnt0, gnt1, s, busy, y_valid, y), pk(0, 0, 0, 0, 0, 8'h00));
    rst = 1'b0;

    // 1. single request, then asynchronous reset mid-burst
    tick();
    req0 = 1'b1; d0 = 8'hA5;
    tick();
    check("t1_grant", pk(gnt0, gnt1, s, busy, y_valid, y), pk(1, 0, 0, 1, 0, 8'h00));
    tick();
    check("t1_sample", pk(gnt0, gnt1, s, busy, y_valid, y), pk(1, 0, 0, 1, 1, 8'hA5));
    #2 rst = 1'b1;
    #1;
    check("t1_async_rst", pk(gnt0, gnt1, s, busy, y_valid, y), pk(0, 0, 0, 0, 0, 8'h00));

    // 2. simultaneous requests out of reset: 4/4 alternation, G0 first
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    tick();
    rst = 1'b0;
    prev_g0 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      g0_exp = (((i - 1) / 4) % 2) == 0;
      if (i == 1)
        check("t2_first", pk(gnt0, gnt1, s, busy, y_valid, y), pk(1, 0, 0, 1, 0, 8'h00));
      else
        check($sformatf("t2_cyc%0d", i), pk(gnt0, gnt1, s, busy, y_valid, y),
              pk(g0_exp, !g0_exp, !g0_exp, 1, 1, prev_g0 ? 8'h11 : 8'h22));
      prev_g0 = g0_exp;
    end

    // 3. hand-off G0 -> G1 without an idle bubble
    req0 = 1'b0; d1 = 8'h3C;
    tick();
    check("t3_handoff", pk(gnt0, gnt1, s, busy, y_valid, y), pk(0, 1, 1, 1, 0, 8'h11));
    tick();
    check("t3_sample", pk(gnt0, gnt1, s, busy, y_valid, y), pk(0, 1, 1, 1, 1, 8'h3C));

    // 4. uncontested requester is never preempted; counter saturates
    for (int i = 0; i < 10; i++) begin
      d1 = 8'h40 + 8'(i);
      tick();
      check($sformatf("t4_cyc%0d", i), pk(gnt0, gnt1, s, busy, y_valid, y),
            pk(0, 1, 1, 1, 1, 8'h40 + 8'(i)));
    end
    check("t4_cnt_sat", 32'(dut.cnt_q), 32'd3);

    // 5. release to idle: select and data hold
    req1 = 1'b0;
    tick();
    check("t5_idle", pk(gnt0, gnt1, s, busy, y_valid, y), pk(0, 0, 1, 0, 0, 8'h49));
    tick();
    check("t5_idle_hold", pk(gnt0, gnt1, s, busy, y_valid, y), pk(0, 0, 1, 0, 0, 8'h49));

    // 6. MAX_BURST=1: grant alternates every cycle under contention
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    #1;
    check("t6_rst", pk(b_gnt0, b_gnt1, b_s, b_busy, b_y_valid, b_y), pk(0, 0, 0, 0, 0, 8'h00));
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("t6_gnt%0d", i), {30'd0, b_gnt0, b_gnt1}, {30'd0, (i % 2) == 1, (i % 2) == 0});
      check($sformatf("t6_onehot%0d", i), {31'd0, b_gnt0 & b_gnt1}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rr_mux21_arbiter

// File: doc/rr_mux21_arbiter.md
Name: rr_mux21_arbiter

Overview:
Arbitrates two requesters for one shared 2:1 datapath channel. Drives the select line of the channel and a registered output stage. Round-robin grant, with a burst limit so one requester cannot hold the channel forever under contention. Sits directly in front of the gate-level 2:1 mux cells and sequences their select input.

Parameters:
WIDTH, 8, data width of d0/d1/y
MAX_BURST, 4, max consecutive grant cycles while the other side is requesting (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
req0  input  1  requester 0 wants channel (level, held for duration of use)
req1  input  1  requester 1 wants channel
d0  input  WIDTH  requester 0 data
d1  input  WIDTH  requester 1 data
gnt0  output  1  requester 0 owns channel (registered)
gnt1  output  1  requester 1 owns channel (registered)
s  output  1  mux select, 0=d0, 1=d1 (registered)
y  output  WIDTH  registered channel output
y_valid  output  1  y carries a fresh sample this cycle
busy  output  1  state != IDLE

Behaviour:
- One clock, clk. Reset is rst: asynchronous, active-high. Everything below is synchronous to the rising edge of clk.
- Reset (async, immediate, also mid-burst): state=IDLE, gnt0=gnt1=0, s=0, y=0, y_valid=0, busy=0, cnt=0, last=1 so requester 0 wins the first tie.
- States: IDLE, G0, G1. gnt0=(state==G0), gnt1=(state==G1), busy=(state!=IDLE).
- IDLE:
  - req0 & req1 -> G(!last).
  - Only reqk -> Gk.
  - None -> stay IDLE.
- Gk:
  - !reqk & req(other) -> G(other), with no IDLE bubble.
  - !reqk & !req(other) -> IDLE.
  - reqk & req(other) & cnt==MAX_BURST-1 -> G(other) (preempt).
  - Otherwise stay Gk.
- Latency: req rising in cycle N gives gnt/s in cycle N+1.
- Grant change: on entry to Gk, s<=k, last<=k, cnt<=0.
- Burst counter: while staying in Gk, cnt increments and saturates at MAX_BURST-1. It only forces a switch when the other side is requesting.
- s holds its last value in IDLE.
- Output stage:
  - In Gk with reqk=1: y<=dk, y_valid<=1 next cycle.
  - Otherwise: y_valid<=0 and y holds.
  - y therefore lags the grant by one cycle. The final sample is taken in the cycle reqk is still high.
- MAX_BURST=1: under continuous contention the grant alternates every cycle.
- cnt width: clog2(MAX_BURST)+1 bits. No overflow possible due to saturation.
- gnt0 and gnt1 are never both 1 (one-hot or zero). Checked by assertion.

Decomposition:
- Shared package mux21_ctrl_pkg holds:
  - state encoding constants IDLE=2'b00, G0=2'b01, G1=2'b10
  - select constants SEL_D0=0, SEL_D1=1
- One sub-module, rr_pick2: combinational next-grant picker. Inputs: req0, req1, last, cur_state, burst_done. Output: next state.
- The top holds the state, cnt, last and output registers.

Test Plan:
1. Reset and single request: assert rst, then hold req0=1, d0=8'hA5 from cycle 1. Response: gnt0=1, s=0 at cycle 2; y=8'hA5, y_valid=1 at cycle 3. Assert rst mid-burst: all outputs go 0 immediately, without waiting for a clock edge.
2. Simultaneous first request: req0=req1=1 out of reset. Response: G0 first (last=1), then G1 after 4 cycles (MAX_BURST=4). The pattern alternates 4/4 while both stay high.
3. Handoff without bubble: in G0, drop req0 while req1=1, d1=8'h3C. Response: gnt1=1 and s=1 next cycle; busy stays 1; y=8'h3C one cycle later.
4. No preemption when uncontested: req1 held alone for 10 cycles. Response: G1 for all 10; cnt saturates at 3; y_valid=1 throughout.
5. Release to idle: drop both reqs in G1. Response: IDLE next cycle; gnt0=gnt1=0, busy=0; s stays 1; y_valid=0, y holds the last value.
6. MAX_BURST=1 build: req0=req1=1 continuously. Response: gnt toggles G0,G1,G0,... every cycle; gnt0&gnt1 never both high.
